voice_allocator: RTL and testbench



---
 rtl/synth_pkg.sv | 20 ++
 rtl/lsb_priority_enc.sv | 23 ++
 rtl/voice_allocator.sv | 142 ++++++++++++++
 tb/tb_voice_allocator.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared synth types: waveform modes, keypad and voice pool sizing.
// Used by the waveform mode FSM and the voice allocator.
package synth_pkg;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        SQUARE = 2'd1,
        SAW    = 2'd2,
        TRI    = 2'd3
    } wave_types;

    localparam int NUM_KEYS   = 13;
    localparam int NUM_VOICES = 4;
    localparam int KEY_W      = $clog2(NUM_KEYS);
    localparam int AGE_W      = $clog2(NUM_VOICES);

    typedef logic [KEY_W-1:0] key_idx_t;
    typedef logic [AGE_W-1:0] age_t;

endpackage

// File: rtl/lsb_priority_enc.sv
// Lowest-set-bit priority encoder.
// valid=0 and idx=0 when no bit is set.
module lsb_priority_enc #(
    parameter int W     = 8,
    parameter int IDX_W = $clog2(W)
) (
    input  logic [W-1:0]     bits,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (bits[i]) begin
                valid = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps held keys onto a voice pool,
// reclaims released voices and steals the oldest when full.
import synth_pkg::wave_types;

module voice_allocator #(
    parameter int NUM_KEYS   = synth_pkg::NUM_KEYS,
    parameter int NUM_VOICES = synth_pkg::NUM_VOICES,
    parameter int KEY_W      = $clog2(NUM_KEYS),
    parameter int AGE_W      = $clog2(NUM_VOICES)
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic [NUM_KEYS-1:0]         keys,
    input  logic [1:0]                  mode,
    output logic [NUM_VOICES-1:0]       voice_active,
    output logic [NUM_VOICES*KEY_W-1:0] voice_key,
    output logic [NUM_VOICES-1:0]       voice_start,
    output logic [NUM_VOICES-1:0]       voice_release,
    output logic                        steal
);

    logic [NUM_VOICES-1:0]       active_q, active_n;
    logic [NUM_VOICES-1:0]       start_q, start_n;
    logic [NUM_VOICES-1:0]       rel_q, rel_n;
    logic [NUM_VOICES*KEY_W-1:0] key_q, key_n;
    logic [NUM_KEYS-1:0]         served_q, served_n;
    logic [AGE_W-1:0]            age_q [NUM_VOICES];
    logic [AGE_W-1:0]            age_n [NUM_VOICES];
    logic                        steal_q, steal_n;

    wave_types             wave;
    logic                  mode_on;
    logic [NUM_VOICES-1:0] key_gone;
    logic [NUM_VOICES-1:0] free_bits;
    logic [NUM_KEYS-1:0]   cand_bits;
    logic                  cand_valid;
    logic [KEY_W-1:0]      cand_idx;
    logic                  free_valid;
    logic [AGE_W-1:0]      free_idx;
    logic [AGE_W-1:0]      oldest;
    logic [AGE_W-1:0]      target;
    logic                  alloc;

    assign wave    = wave_types'(mode);
    assign mode_on = (wave != synth_pkg::OFF);

    always_comb begin
        key_gone = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            key_gone[v] = active_q[v]
                        & ~keys[key_q[v*KEY_W +: KEY_W]];
        end
    end

    // served & keys, then & ~served, reduces to keys & ~served
    assign cand_bits = keys & ~served_q;
    assign free_bits = ~active_q | key_gone;

    lsb_priority_enc #(
        .W     (NUM_KEYS),
        .IDX_W (KEY_W)
    ) u_cand_enc (
        .bits  (cand_bits),
        .valid (cand_valid),
        .idx   (cand_idx)
    );

    lsb_priority_enc #(
        .W     (NUM_VOICES),
        .IDX_W (AGE_W)
    ) u_free_enc (
        .bits  (free_bits),
        .valid (free_valid),
        .idx   (free_idx)
    );

    always_comb begin
        oldest = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (age_q[v] == AGE_W'(NUM_VOICES - 1)) begin
                oldest = AGE_W'(v);
            end
        end
    end

    assign alloc  = mode_on & cand_valid;
    assign target = free_valid ? free_idx : oldest;

    always_comb begin
        active_n = mode_on ? (active_q & ~key_gone) : '0;
        rel_n    = mode_on ? key_gone : active_q;
        served_n = mode_on ? (served_q & keys) : '0;
        start_n  = '0;
        steal_n  = 1'b0;
        key_n    = key_q;
        age_n    = age_q;
        if (alloc) begin
            active_n[target] = 1'b1;
            rel_n[target]    = 1'b0;
            start_n[target]  = 1'b1;
            steal_n          = ~free_valid;
            served_n[cand_idx] = 1'b1;
            key_n[target*KEY_W +: KEY_W] = cand_idx;
            // move-to-front of the recency order
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (age_q[v] < age_q[target]) begin
                    age_n[v] = age_q[v] + 1'b1;
                end
            end
            age_n[target] = '0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            active_q <= '0;
            start_q  <= '0;
            rel_q    <= '0;
            key_q    <= '0;
            served_q <= '0;
            steal_q  <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                age_q[v] <= AGE_W'(v);
            end
        end else begin
            active_q <= active_n;
            start_q  <= start_n;
            rel_q    <= rel_n;
            key_q    <= key_n;
            served_q <= served_n;
            steal_q  <= steal_n;
            age_q    <= age_n;
        end
    end

    assign voice_active  = active_q;
    assign voice_key     = key_q;
    assign voice_start   = start_q;
    assign voice_release = rel_q;
    assign steal         = steal_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: recency-list model, directed
// scenarios with literal expectations, then random key traffic.
module tb_voice_allocator;

    localparam int NK = 13;
    localparam int NV = 4;
    localparam int KW = 4;

    logic             clk = 1'b0;
    logic             n_rst;
    logic [NK-1:0]    keys;
    logic [1:0]       mode;
    logic [NV-1:0]    voice_active;
    logic [NV*KW-1:0] voice_key;
    logic [NV-1:0]    voice_start;
    logic [NV-1:0]    voice_release;
    logic             steal;

    int checks = 0;
    int errors = 0;

    logic [NV-1:0] m_active;
    logic [NV-1:0] m_start;
    logic [NV-1:0] m_rel;
    logic          m_steal;
    logic [NK-1:0] m_served;
    int            m_key [NV];
    int            lru [$];

    voice_allocator dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .keys          (keys),
        .mode          (mode),
        .voice_active  (voice_active),
        .voice_key     (voice_key),
        .voice_start   (voice_start),
        .voice_release (voice_release),
        .steal         (steal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = '0;
        m_start  = '0;
        m_rel    = '0;
        m_steal  = 1'b0;
        m_served = '0;
        for (int v = 0; v < NV; v++) m_key[v] = 0;
        lru = {0, 1, 2, 3};
    endtask

    // lru[0] is the most recently started voice
    task automatic model_step();
        int cand;
        int tgt;
        int pos;
        m_start = '0;
        m_rel   = '0;
        m_steal = 1'b0;
        if (!n_rst) begin
            model_reset();
            return;
        end
        if (mode == 2'd0) begin
            m_rel    = m_active;
            m_active = '0;
            m_served = '0;
            return;
        end
        for (int v = 0; v < NV; v++) begin
            if (m_active[v] && !keys[m_key[v]]) begin
                m_active[v] = 1'b0;
                m_rel[v]    = 1'b1;
            end
        end
        m_served = m_served & keys;
        cand = -1;
        for (int k = 0; k < NK; k++)
            if (cand < 0 && keys[k] && !m_served[k]) cand = k;
        if (cand < 0) return;
        tgt = -1;
        for (int v = 0; v < NV; v++)
            if (tgt < 0 && !m_active[v]) tgt = v;
        if (tgt < 0) begin
            tgt     = lru[NV-1];
            m_steal = 1'b1;
        end
        m_key[tgt]     = cand;
        m_active[tgt]  = 1'b1;
        m_start[tgt]   = 1'b1;
        m_rel[tgt]     = 1'b0;
        m_served[cand] = 1'b1;
        pos = 0;
        for (int i = 0; i < lru.size(); i++)
            if (lru[i] == tgt) pos = i;
        lru.delete(pos);
        lru.push_front(tgt);
    endtask

    task automatic compare_all();
        logic [NV*KW-1:0] ek;
        ek = '0;
        for (int v = 0; v < NV; v++) begin
            logic [31:0] kv;
            kv = m_key[v];
            ek[v*KW +: KW] = kv[KW-1:0];
        end
        chk("active",  32'(voice_active),  32'(m_active));
        chk("key",     32'(voice_key),     32'(ek));
        chk("start",   32'(voice_start),   32'(m_start));
        chk("release", 32'(voice_release), 32'(m_rel));
        chk("steal",   32'(steal),         32'(m_steal));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        model_reset();
        #1;
        compare_all();
        keys = '0;
        mode = 2'd1;
        tick();
        n_rst = 1'b1;
    endtask

    initial begin
        n_rst = 1'b0;
        keys  = '1;
        mode  = 2'd1;
        model_reset();
        #1;
        tick();
        tick();
        chk("rst_active", 32'(voice_active), 32'h0);
        chk("rst_key",    32'(voice_key),    32'h0);
        chk("rst_start",  32'(voice_start),  32'h0);
        n_rst = 1'b1;
        tick();
        chk("boot_start0", 32'(voice_start), 32'h1);
        chk("boot_key0",   32'(voice_key[3:0]), 32'h0);
        tick();
        chk("boot_start1", 32'(voice_start), 32'h2);
        chk("boot_key1",   32'(voice_key[7:4]), 32'h1);
        tick();
        tick();
        chk("boot_start3", 32'(voice_start), 32'h8);
        chk("boot_steal",  32'(steal), 32'h0);

        do_reset();
        tick();
        keys = 13'h0020;
        tick();
        chk("k5_active", 32'(voice_active), 32'h1);
        chk("k5_key",    32'(voice_key[3:0]), 32'h5);
        chk("k5_start",  32'(voice_start), 32'h1);
        keys = '0;
        tick();
        chk("k5_rel",    32'(voice_release), 32'h1);
        chk("k5_off",    32'(voice_active), 32'h0);

        do_reset();
        keys = 13'h000f;
        repeat (4) tick();
        keys = 13'h020f;
        tick();
        chk("steal_start", 32'(voice_start), 32'h1);
        chk("steal_flag",  32'(steal), 32'h1);
        chk("steal_key",   32'(voice_key[3:0]), 32'h9);
        keys = 13'h020e;
        tick();
        chk("stolen_rel",   32'(voice_release), 32'h0);
        chk("stolen_start", 32'(voice_start), 32'h0);
        chk("stolen_act",   32'(voice_active), 32'hf);

        do_reset();
        keys = 13'h001e;
        repeat (4) tick();
        keys = 13'h009a;
        tick();
        chk("swap_start", 32'(voice_start), 32'h2);
        chk("swap_rel",   32'(voice_release), 32'h0);
        chk("swap_key",   32'(voice_key[7:4]), 32'h7);

        do_reset();
        keys = 13'h004f;
        tick();
        keys = 13'h000f;
        repeat (5) tick();
        chk("tap_keys",   32'(voice_key), 32'h3210);
        chk("tap_active", 32'(voice_active), 32'hf);
        chk("tap_start",  32'(voice_start), 32'h0);
        mode = 2'd0;
        tick();
        chk("off_rel",    32'(voice_release), 32'hf);
        chk("off_active", 32'(voice_active), 32'h0);
        mode = 2'd2;
        keys = 13'h0110;
        tick();
        chk("on_start0", 32'(voice_start), 32'h1);
        chk("on_key0",   32'(voice_key[3:0]), 32'h4);
        tick();
        chk("on_start1", 32'(voice_start), 32'h2);
        chk("on_key1",   32'(voice_key[7:4]), 32'h8);

        do_reset();
        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < NK; k++)
                if ($urandom_range(0, 7) == 0) keys[k] = ~keys[k];
            if ($urandom_range(0, 63) == 0)
                mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 499) == 0) begin
                n_rst = 1'b0;
                model_reset();
                #1;
                compare_all();
                tick();
                n_rst = 1'b1;
            end else begin
                tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
